// File: rtl/divider.sv
// -----------------------------------------------------------------------------
// divider -- sequential restoring divider with mixed-signedness operands.
//
// Computes a truncating quotient (rounded toward zero) and a remainder that
// carries the dividend's sign. A start pulse latches the operands. The core
// then performs BW_DVDND shift-subtract steps on unsigned magnitudes. A final
// correction cycle applies the result signs and evaluates the flags. Latency
// from the start edge to the result update is BW_DVDND+1 cycles.
//
// Parameters
//   BW_DVDND : dividend / quotient width (>= 2)
//   BW_DVSR  : divisor / remainder width (>= 2, <= BW_DVDND)
//   BW_CNT   : step counter width, ceil(log2(BW_DVDND+2))
//
// Ports
//   clk             in   clock, rising edge
//   rstx            in   asynchronous active-low reset
//   clear           in   synchronous abort, zeroes all state (beats start)
//   start           in   one-cycle request, samples operands and signedness
//   dvdnd_is_signed in   dividend is two's complement
//   dvsr_is_signed  in   divisor is two's complement
//   dvdnd           in   dividend [BW_DVDND]
//   dvsr            in   divisor  [BW_DVSR]
//   quot            out  registered quotient [BW_DVDND]
//   rem             out  registered remainder [BW_DVSR]
//   busy            out  operation in progress (cnt != 0)
//   done            out  one-cycle pulse after quot/rem are updated
//   div_by_zero     out  divisor was zero for the last result
//   ovf             out  quotient of the last result not representable
// -----------------------------------------------------------------------------
module divider #(
   parameter int BW_DVDND = 8,
   parameter int BW_DVSR  = 4,
   parameter int BW_CNT   = 4
) (
   input  logic                clk,
   input  logic                rstx,
   input  logic                clear,
   input  logic                start,
   input  logic                dvdnd_is_signed,
   input  logic                dvsr_is_signed,
   input  logic [BW_DVDND-1:0] dvdnd,
   input  logic [BW_DVSR-1:0]  dvsr,
   output logic [BW_DVDND-1:0] quot,
   output logic [BW_DVSR-1:0]  rem,
   output logic                busy,
   output logic                done,
   output logic                div_by_zero,
   output logic                ovf
);

   localparam logic [BW_CNT-1:0]   CNT_LOAD  = BW_CNT'(BW_DVDND + 1);
   localparam logic [BW_CNT-1:0]   CNT_ONE   = BW_CNT'(1);
   // Magnitude of the most negative quotient, 100..0.
   localparam logic [BW_DVDND-1:0] Q_MIN_MAG = {1'b1, {(BW_DVDND-1){1'b0}}};

   // Working registers
   logic [BW_CNT-1:0]   cnt_q,    cnt_d;
   logic [BW_DVDND-1:0] qw_q,     qw_d;      // dividend bits shifting out, quotient bits in
   logic [BW_DVSR-1:0]  rw_q,     rw_d;      // partial remainder
   logic [BW_DVSR-1:0]  dv_q,     dv_d;      // divisor magnitude
   logic                neg_q_q,  neg_q_d;   // quotient must be negated
   logic                neg_r_q,  neg_r_d;   // remainder must be negated
   logic                sgn_q,    sgn_d;     // result is signed
   logic                dz_q,     dz_d;      // divisor was zero
   logic                ovw_q,    ovw_d;     // overflow flag (working copy)

   // Result registers
   logic [BW_DVDND-1:0] quot_q,   quot_d;
   logic [BW_DVSR-1:0]  rem_q,    rem_d;
   logic                dbz_q,    dbz_d;
   logic                ovf_q,    ovf_d;
   logic                done_q,   done_d;

   // Step and correction datapath
   logic [BW_DVSR:0]    pr;
   logic [BW_DVSR:0]    diff;
   logic                ge;
   logic [BW_DVDND-1:0] q_signed;
   logic [BW_DVSR-1:0]  r_signed;
   logic [BW_DVDND-1:0] quot_c;
   logic [BW_DVSR-1:0]  rem_c;
   logic                ovf_c;

   function automatic logic [BW_DVDND-1:0] mag_dvdnd(input logic [BW_DVDND-1:0] v,
                                                      input logic s);
      // Magnitude of the most negative value wraps to 100..0, which is the
      // correct unsigned magnitude in BW_DVDND bits.
      if (s && v[BW_DVDND-1]) return ~v + BW_DVDND'(1);
      else                    return v;
   endfunction

   function automatic logic [BW_DVSR-1:0] mag_dvsr(input logic [BW_DVSR-1:0] v,
                                                    input logic s);
      if (s && v[BW_DVSR-1]) return ~v + BW_DVSR'(1);
      else                   return v;
   endfunction

   always_comb begin
      // One restoring step: bring in the next dividend bit, subtract if it fits.
      // When it does not fit, pr < divisor, so it fits in BW_DVSR bits.
      pr   = {rw_q, qw_q[BW_DVDND-1]};
      diff = pr - {1'b0, dv_q};
      ge   = (pr >= {1'b0, dv_q});

      q_signed = neg_q_q ? (~qw_q + BW_DVDND'(1)) : qw_q;
      r_signed = neg_r_q ? (~rw_q + BW_DVSR'(1))  : rw_q;

      // A positive signed quotient overflows at 2^(BW_DVDND-1) and above.
      // A negative one overflows only beyond that magnitude.
      ovf_c = sgn_q & ~dz_q &
              (neg_q_q ? (qw_q > Q_MIN_MAG) : qw_q[BW_DVDND-1]);
      quot_c = dz_q ? {BW_DVDND{1'b1}} : q_signed;
      rem_c  = dz_q ? {BW_DVSR{1'b0}}  : r_signed;
   end

   always_comb begin
      cnt_d   = cnt_q;
      qw_d    = qw_q;
      rw_d    = rw_q;
      dv_d    = dv_q;
      neg_q_d = neg_q_q;
      neg_r_d = neg_r_q;
      sgn_d   = sgn_q;
      dz_d    = dz_q;
      ovw_d   = ovw_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      ovf_d   = ovf_q;
      done_d  = 1'b0;

      if (clear) begin
         cnt_d   = '0;
         qw_d    = '0;
         rw_d    = '0;
         dv_d    = '0;
         neg_q_d = 1'b0;
         neg_r_d = 1'b0;
         sgn_d   = 1'b0;
         dz_d    = 1'b0;
         ovw_d   = 1'b0;
         quot_d  = '0;
         rem_d   = '0;
         dbz_d   = 1'b0;
         ovf_d   = 1'b0;
      end else if (start) begin
         // A start while busy simply overwrites the working state, so the
         // aborted operation never reaches its correction cycle.
         cnt_d   = CNT_LOAD;
         qw_d    = mag_dvdnd(dvdnd, dvdnd_is_signed);
         rw_d    = '0;
         dv_d    = mag_dvsr(dvsr, dvsr_is_signed);
         neg_r_d = dvdnd_is_signed & dvdnd[BW_DVDND-1];
         neg_q_d = (dvdnd_is_signed & dvdnd[BW_DVDND-1]) ^
                   (dvsr_is_signed & dvsr[BW_DVSR-1]);
         sgn_d   = dvdnd_is_signed | dvsr_is_signed;
         dz_d    = (dvsr == '0);
         ovw_d   = 1'b0;
      end else if (cnt_q > CNT_ONE) begin
         qw_d  = {qw_q[BW_DVDND-2:0], ge};
         rw_d  = ge ? diff[BW_DVSR-1:0] : pr[BW_DVSR-1:0];
         cnt_d = cnt_q - CNT_ONE;
      end else if (cnt_q == CNT_ONE) begin
         // Correction cycle: signs applied, flags evaluated, results published.
         qw_d   = quot_c;
         rw_d   = rem_c;
         ovw_d  = ovf_c;
         cnt_d  = '0;
         quot_d = quot_c;
         rem_d  = rem_c;
         dbz_d  = dz_q;
         ovf_d  = ovf_c;
         done_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstx) begin
      if (!rstx) begin
         cnt_q   <= '0;
         qw_q    <= '0;
         rw_q    <= '0;
         dv_q    <= '0;
         neg_q_q <= 1'b0;
         neg_r_q <= 1'b0;
         sgn_q   <= 1'b0;
         dz_q    <= 1'b0;
         ovw_q   <= 1'b0;
         quot_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         qw_q    <= qw_d;
         rw_q    <= rw_d;
         dv_q    <= dv_d;
         neg_q_q <= neg_q_d;
         neg_r_q <= neg_r_d;
         sgn_q   <= sgn_d;
         dz_q    <= dz_d;
         ovw_q   <= ovw_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
      end
   end

   assign quot        = quot_q;
   assign rem         = rem_q;
   assign busy        = (cnt_q != '0);
   assign done        = done_q;
   assign div_by_zero = dbz_q;
   assign ovf         = ovf_q;

endmodule

// File: tb/tb_divider.sv
// -----------------------------------------------------------------------------
// tb_divider -- self-checking bench for divider at default widths 8/4/4.
// It applies a table of directed vectors, then randomized operations checked
// against an integer-arithmetic reference. It also runs hand-written
// sequences for clear, restart-while-busy and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_divider;

   logic       clk = 1'b0;
   logic       rstx;
   logic       clear;
   logic       start;
   logic       dvdnd_is_signed;
   logic       dvsr_is_signed;
   logic [7:0] dvdnd;
   logic [3:0] dvsr;
   logic [7:0] quot;
   logic [3:0] rem;
   logic       busy;
   logic       done;
   logic       div_by_zero;
   logic       ovf;

   int checks = 0;
   int errors = 0;

   // Result the outputs must hold until the next update.
   logic [7:0] hq;
   logic [3:0] hr;
   logic       hdz;
   logic       hov;

   typedef struct {
      logic [7:0] a;
      logic [3:0] b;
      logic       sa;
      logic       sb;
      logic [7:0] q;
      logic [3:0] r;
      logic       dz;
      logic       ov;
   } vec_t;

   vec_t tbl[13];

   divider #(.BW_DVDND(8), .BW_DVSR(4), .BW_CNT(4)) dut (
      .clk             (clk),
      .rstx            (rstx),
      .clear           (clear),
      .start           (start),
      .dvdnd_is_signed (dvdnd_is_signed),
      .dvsr_is_signed  (dvsr_is_signed),
      .dvdnd           (dvdnd),
      .dvsr            (dvsr),
      .quot            (quot),
      .rem             (rem),
      .busy            (busy),
      .done            (done),
      .div_by_zero     (div_by_zero),
      .ovf             (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference: plain integer division, which truncates toward zero.
   task automatic model(input logic [7:0] a, input logic [3:0] b, input logic sa, input logic sb,
                        output logic [7:0] q, output logic [3:0] r,
                        output logic dz, output logic ov);
      int ai, bi, qi, ri;
      if (sa) ai = int'($signed(a)); else ai = int'(a);
      if (sb) bi = int'($signed(b)); else bi = int'(b);
      if (bi == 0) begin
         q = 8'hFF; r = 4'h0; dz = 1'b1; ov = 1'b0;
      end else begin
         qi = ai / bi;
         ri = ai % bi;
         q  = qi[7:0];
         r  = ri[3:0];
         dz = 1'b0;
         ov = (sa | sb) && (qi > 127 || qi < -128);
      end
   endtask

   // Called just after a falling edge: pulses start for one cycle, then
   // scrambles the operand inputs so they must be ignored.
   task automatic launch(input logic [7:0] a, input logic [3:0] b, input logic sa, input logic sb);
      dvdnd = a; dvsr = b; dvdnd_is_signed = sa; dvsr_is_signed = sb;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      dvdnd = 8'($urandom);
      dvsr  = 4'($urandom);
      dvdnd_is_signed = 1'($urandom);
      dvsr_is_signed  = 1'($urandom);
   endtask

   // Called at the first falling edge after the start edge.
   task automatic wait_result(input string name, input logic [7:0] eq, input logic [3:0] er,
                              input logic edz, input logic eov);
      int bc = 0;
      int dn = 0;
      logic hold_ok = 1'b1;
      while (busy === 1'b1 && bc < 40) begin
         bc++;
         if (done !== 1'b0) dn++;
         if (quot !== hq || rem !== hr || div_by_zero !== hdz || ovf !== hov) hold_ok = 1'b0;
         @(negedge clk);
      end
      check({name, " busy_cycles"}, bc, 9);
      check({name, " done_in_busy"}, dn, 0);
      check({name, " hold"}, hold_ok, 1);
      check({name, " done"}, done, 1);
      check({name, " quot"}, quot, eq);
      check({name, " rem"}, rem, er);
      check({name, " div_by_zero"}, div_by_zero, edz);
      check({name, " ovf"}, ovf, eov);
      @(negedge clk);
      check({name, " done_pulse"}, done, 0);
      hq = eq; hr = er; hdz = edz; hov = eov;
   endtask

   initial begin
      logic [7:0] a, mq;
      logic [3:0] b, mr;
      logic       sa, sb, mdz, mov;
      int         dn;

      tbl[0]  = '{8'd200, 4'd7,  1'b0, 1'b0, 8'd28,  4'd4,  1'b0, 1'b0};
      tbl[1]  = '{8'h9C,  4'd7,  1'b1, 1'b1, 8'hF2,  4'hE,  1'b0, 1'b0};
      tbl[2]  = '{8'd100, 4'hD,  1'b1, 1'b1, 8'hDF,  4'h1,  1'b0, 1'b0};
      tbl[3]  = '{8'd55,  4'h0,  1'b0, 1'b0, 8'hFF,  4'h0,  1'b1, 1'b0};
      tbl[4]  = '{8'h80,  4'hF,  1'b1, 1'b1, 8'h80,  4'h0,  1'b0, 1'b1};
      tbl[5]  = '{8'd200, 4'hD,  1'b0, 1'b1, 8'hBE,  4'h2,  1'b0, 1'b0};
      tbl[6]  = '{8'hFF,  4'hF,  1'b0, 1'b1, 8'h01,  4'h0,  1'b0, 1'b1};
      tbl[7]  = '{8'h80,  4'hF,  1'b1, 1'b0, 8'hF8,  4'h8,  1'b0, 1'b0};
      tbl[8]  = '{8'hF9,  4'h0,  1'b1, 1'b1, 8'hFF,  4'h0,  1'b1, 1'b0};
      tbl[9]  = '{8'h7F,  4'h1,  1'b1, 1'b1, 8'h7F,  4'h0,  1'b0, 1'b0};
      tbl[10] = '{8'h80,  4'h1,  1'b1, 1'b1, 8'h80,  4'h0,  1'b0, 1'b0};
      tbl[11] = '{8'h80,  4'h8,  1'b1, 1'b1, 8'h10,  4'h0,  1'b0, 1'b0};
      tbl[12] = '{8'hFF,  4'hF,  1'b0, 1'b0, 8'h11,  4'h0,  1'b0, 1'b0};

      rstx = 1'b0; clear = 1'b0; start = 1'b0;
      dvdnd = '0; dvsr = '0; dvdnd_is_signed = 1'b0; dvsr_is_signed = 1'b0;
      hq = '0; hr = '0; hdz = 1'b0; hov = 1'b0;
      repeat (2) @(negedge clk);
      check("reset quot", quot, 0);
      check("reset rem", rem, 0);
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset div_by_zero", div_by_zero, 0);
      check("reset ovf", ovf, 0);
      rstx = 1'b1;
      @(negedge clk);

      // Directed vectors
      for (int i = 0; i < 13; i++) begin
         launch(tbl[i].a, tbl[i].b, tbl[i].sa, tbl[i].sb);
         wait_result($sformatf("vec%0d", i), tbl[i].q, tbl[i].r, tbl[i].dz, tbl[i].ov);
      end

      // Clear three cycles into an operation
      launch(8'd200, 4'd7, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check("clear busy", busy, 0);
      check("clear quot", quot, 0);
      check("clear rem", rem, 0);
      check("clear div_by_zero", div_by_zero, 0);
      check("clear ovf", ovf, 0);
      check("clear done", done, 0);
      dn = 0;
      for (int i = 0; i < 12; i++) begin
         if (done !== 1'b0) dn++;
         @(negedge clk);
      end
      check("clear no_done", dn, 0);
      hq = '0; hr = '0; hdz = 1'b0; hov = 1'b0;

      // Restart while busy: only the second result may appear
      launch(8'd200, 4'd7, 1'b0, 1'b0);
      dn = 0;
      for (int i = 0; i < 3; i++) begin
         if (done !== 1'b0) dn++;
         @(negedge clk);
      end
      launch(8'h9C, 4'd7, 1'b1, 1'b1);
      check("restart no_done_first", dn, 0);
      wait_result("restart", 8'hF2, 4'hE, 1'b0, 1'b0);

      // Randomized operations against the reference
      for (int i = 0; i < 60; i++) begin
         a  = 8'($urandom);
         b  = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
         sa = 1'($urandom);
         sb = 1'($urandom);
         if (i % 10 == 0) begin a = 8'h80; b = 4'hF; end
         model(a, b, sa, sb, mq, mr, mdz, mov);
         launch(a, b, sa, sb);
         wait_result($sformatf("rnd%0d a=%0h b=%0h sa=%0b sb=%0b", i, a, b, sa, sb),
                     mq, mr, mdz, mov);
      end

      // Asynchronous reset mid-operation, then start on the first edge after release
      launch(8'd200, 4'd7, 1'b0, 1'b0);
      @(negedge clk);
      #2 rstx = 1'b0;
      #1;
      check("async_reset busy", busy, 0);
      check("async_reset quot", quot, 0);
      check("async_reset rem", rem, 0);
      @(negedge clk);
      hq = '0; hr = '0; hdz = 1'b0; hov = 1'b0;
      rstx = 1'b1;
      launch(8'd100, 4'hD, 1'b1, 1'b1);
      wait_result("post_reset", 8'hDF, 4'h1, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 SHALL have parameter BW_DVDND, default 8, meaning dividend and quotient width (>=2).
REQ-002 SHALL have parameter BW_DVSR, default 4, meaning divisor and remainder width (>=2, <=BW_DVDND).
REQ-003 SHALL have parameter BW_CNT, default 4, meaning counter width, equal to ceiling(log2(BW_DVDND+2)).
REQ-004 SHALL have port clk  input  1  clock, all state updated on rising edge.
REQ-005 SHALL have port rstx  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port clear  input  1  synchronous abort and zeroing of all state.
REQ-007 SHALL have port start  input  1  one-cycle request; operands and signedness sampled this cycle.
REQ-008 SHALL have port dvdnd_is_signed  input  1  dividend is two's complement when 1.
REQ-009 SHALL have port dvsr_is_signed  input  1  divisor is two's complement when 1.
REQ-010 SHALL have port dvdnd  input  BW_DVDND  dividend.
REQ-011 SHALL have port dvsr  input  BW_DVSR  divisor.
REQ-012 SHALL have port quot  output  BW_DVDND  quotient, registered.
REQ-013 SHALL have port rem  output  BW_DVSR  remainder, registered.
REQ-014 SHALL have port busy  output  1  operation in progress.
REQ-015 SHALL have port done  output  1  one-cycle pulse when quot/rem updated.
REQ-016 SHALL have port div_by_zero  output  1  result flag, divisor was zero.
REQ-017 SHALL have port ovf  output  1  result flag, quotient not representable.

Function
REQ-018 SHALL implement truncating division: quotient rounds toward zero; remainder has dividend's sign (or is 0); dvdnd = quot*dvsr + rem when no flag set.
REQ-019 Result signed iff dvdnd_is_signed|dvsr_is_signed; each operand interpreted per its own flag, mixed signedness allowed.
REQ-020 On start: latch operand magnitudes, result signs, and zero-divisor detection into working registers; load cnt = BW_DVDND+1.
REQ-021 While cnt >= 2: one restoring shift-subtract step per cycle on unsigned magnitudes, MSB of dividend first; cnt decrements.
REQ-022 While cnt == 1: correction cycle -- conditional two's-complement negation of quotient and remainder, flag evaluation; cnt -> 0.
REQ-023 On the cnt 1->0 edge: quot, rem, div_by_zero, ovf SHALL load from working registers, and done SHALL be 1 for exactly the following cycle.
REQ-024 busy SHALL equal (cnt != 0); busy high exactly BW_DVDND+1 cycles after the start cycle.
REQ-025 quot, rem, flags SHALL hold prior result throughout busy and until next update or clear.
REQ-026 Divisor zero: quot = all ones, rem = 0, div_by_zero = 1, ovf = 0, same latency.
REQ-027 Signed result with quotient magnitude 2^(BW_DVDND-1) and positive sign (e.g. most-negative / -1): quot = wrapped value 100..0, rem = 0, ovf = 1.
REQ-028 Unsigned dividend, signed negative divisor with magnitude quotient exceeding signed range: quot SHALL be low BW_DVDND bits of the true result, ovf = 1.
REQ-029 start while busy SHALL abort current operation and restart with new operands; no done for the aborted one.
REQ-030 clear SHALL have priority over start; clear zeroes cnt, working registers, quot, rem, flags, done on next edge.
REQ-031 Inputs dvdnd, dvsr, signedness flags SHALL be ignored in all cycles except start cycle.

Reset
REQ-032 rstx low SHALL asynchronously force cnt=0, quot=0, rem=0, busy=0, done=0, div_by_zero=0, ovf=0, working registers=0.
REQ-033 First start SHALL be accepted on the first rising edge with rstx high.

Verification (defaults 8/4/4)
REQ-034 Unsigned 200/7 -> quot 8'd28, rem 4'd4, busy 9 cycles, done 1 cycle after busy falls, flags 0.
REQ-035 Both signed, -100 (8'h9C) / 7 -> quot 8'hF2 (-14), rem 4'hE (-2), flags 0.
REQ-036 Both signed, 100 / -3 (4'hD) -> quot 8'hDF (-33), rem 4'h1.
REQ-037 55 / 0 -> quot 8'hFF, rem 4'h0, div_by_zero 1; both signed, -128 (8'h80) / -1 (4'hF) -> quot 8'h80, rem 0, ovf 1.
REQ-038 clear asserted 3 cycles into an operation -> busy 0 next cycle, quot/rem/flags 0, no done pulse; start during busy -> only second result appears, 9 cycles after restart.
